// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, framer state encoding and output beat type.
package eth_pkg;

  localparam int unsigned ETH_HDR_BYTES   = 14;
  localparam int unsigned ETH_FCS_BYTES   = 4;
  localparam int unsigned ETH_MIN_PAYLOAD = 46;
  localparam int unsigned PAY_CNT_W       = 11;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned HDR_W           = 8 * ETH_HDR_BYTES;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [47:0] MAC_BCAST       = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_SRC_DEFAULT = 48'h02_00_00_00_00_01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS
  } eth_tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } eth_beat_t;

  // Header byte idx counted from the first byte on the wire.
  function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0] hdr, input logic [IDX_W-1:0] idx);
    logic [HDR_W-1:0] sh;
    sh = hdr << {idx, 3'b000};
    return sh[HDR_W-1 -: 8];
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32 (LSB of data first).
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: header insertion, payload pass-through,
// zero padding to the minimum payload and CRC-32 FCS append.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = MAC_BCAST,
  parameter logic [47:0] SRC_MAC     = MAC_SRC_DEFAULT,
  parameter logic [15:0] ETHERTYPE   = ETHERTYPE_IPV4,
  parameter int unsigned MIN_PAYLOAD = ETH_MIN_PAYLOAD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       busy
);

  localparam logic [HDR_W-1:0]     HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [PAY_CNT_W-1:0] PAY_MAX  = '1;
  localparam logic [PAY_CNT_W-1:0] MIN_CNT  = PAY_CNT_W'(MIN_PAYLOAD);
  localparam logic [IDX_W-1:0]     HDR_LAST = IDX_W'(ETH_HDR_BYTES - 1);
  localparam logic [IDX_W-1:0]     FCS_LAST = IDX_W'(ETH_FCS_BYTES - 1);
  localparam logic [IDX_W-1:0]     FCS_DONE = IDX_W'(ETH_FCS_BYTES);

  eth_tx_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PAY_CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [31:0]          crc_q, crc_d;
  eth_beat_t            beat_q, beat_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic                 load_c;
  logic [7:0]           byte_c;
  logic [31:0]          crc_base_c;
  logic [31:0]          crc_next_c;
  logic [31:0]          fcs_c;
  logic [7:0]           fcs_byte_c;
  logic [PAY_CNT_W-1:0] pay_cnt_inc_c;

  assign load_c        = !valid_q || m_axis_tready;
  assign s_axis_tready = (state_q == ST_PAYLOAD) && load_c;

  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tlast  = beat_q.last;
  assign m_axis_tvalid = valid_q;
  assign busy          = busy_q;

  assign pay_cnt_inc_c = (pay_cnt_q == PAY_MAX) ? pay_cnt_q : pay_cnt_q + 1'b1;
  assign fcs_c         = ~crc_q;
  assign fcs_byte_c    = fcs_c[{idx_q[1:0], 3'b000} +: 8];
  assign crc_base_c    = (state_q == ST_IDLE) ? CRC32_INIT : crc_q;

  // Byte that would be loaded into the output register this cycle.
  always_comb begin
    byte_c = 8'h00;
    case (state_q)
      ST_IDLE:    byte_c = hdr_byte(HDR, IDX_W'(0));
      ST_HDR:     byte_c = hdr_byte(HDR, idx_q);
      ST_PAYLOAD: byte_c = s_axis_tdata;
      default:    byte_c = 8'h00;
    endcase
  end

  eth_crc32_byte u_crc (
    .crc_in  (crc_base_c),
    .data    (byte_c),
    .crc_out (crc_next_c)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pay_cnt_d = pay_cnt_q;
    crc_d     = crc_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    busy_d    = busy_q;

    if (load_c) begin
      case (state_q)
        ST_IDLE: begin
          crc_d       = CRC32_INIT;
          valid_d     = 1'b0;
          beat_d.last = 1'b0;
          idx_d       = '0;
          pay_cnt_d   = '0;
          if (s_axis_tvalid) begin
            state_d = ST_HDR;
            beat_d  = '{data: byte_c, last: 1'b0};
            valid_d = 1'b1;
            crc_d   = crc_next_c;
            idx_d   = IDX_W'(1);
            busy_d  = 1'b1;
          end
        end
        ST_HDR: begin
          beat_d  = '{data: byte_c, last: 1'b0};
          valid_d = 1'b1;
          crc_d   = crc_next_c;
          if (idx_q == HDR_LAST) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
        ST_PAYLOAD: begin
          // An upstream bubble empties the output register instead of stalling it.
          if (s_axis_tvalid) begin
            beat_d    = '{data: byte_c, last: 1'b0};
            valid_d   = 1'b1;
            crc_d     = crc_next_c;
            pay_cnt_d = pay_cnt_inc_c;
            if (s_axis_tlast) state_d = (pay_cnt_inc_c < MIN_CNT) ? ST_PAD : ST_FCS;
          end else begin
            valid_d   = 1'b0;
          end
        end
        ST_PAD: begin
          beat_d    = '{data: 8'h00, last: 1'b0};
          valid_d   = 1'b1;
          crc_d     = crc_next_c;
          pay_cnt_d = pay_cnt_inc_c;
          if (pay_cnt_inc_c >= MIN_CNT) state_d = ST_FCS;
        end
        ST_FCS: begin
          if (idx_q == FCS_DONE) begin
            state_d     = ST_IDLE;
            valid_d     = 1'b0;
            beat_d.last = 1'b0;
            idx_d       = '0;
            busy_d      = 1'b0;
          end else begin
            beat_d  = '{data: fcs_byte_c, last: (idx_q == FCS_LAST)};
            valid_d = 1'b1;
            idx_d   = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pay_cnt_q <= '0;
      crc_q     <= CRC32_INIT;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pay_cnt_q <= pay_cnt_d;
      crc_q     <= crc_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: CRC unit, padded/unpadded frames,
// stall stability and mid-frame reset recovery.
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast;
  logic       busy;

  logic [31:0] cu_in;
  logic [7:0]  cu_data;
  logic [31:0] cu_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         got_last[$];

  bit         rand_rdy = 1'b0;
  bit         mon_chk_busy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always #5 clk = ~clk;

  eth_tx_framer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .busy          (busy)
  );

  eth_crc32_byte u_crc_unit (
    .crc_in  (cu_in),
    .data    (cu_data),
    .crc_out (cu_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MSB-first (non-reflected) CRC-32 on bit-reversed bytes.
  function automatic logic [31:0] crc_norm(input logic [31:0] r, input logic [7:0] d);
    logic [7:0]  rd;
    logic [31:0] x;
    for (int i = 0; i < 8; i++) rd[i] = d[7-i];
    x = r ^ {rd, 24'h000000};
    for (int i = 0; i < 8; i++) x = x[31] ? ((x << 1) ^ 32'h04C1_1DB7) : (x << 1);
    return x;
  endfunction

  task automatic build_exp();
    logic [7:0]  hdr [14];
    logic [31:0] r;
    logic [31:0] fcs;
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(hdr[i]);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    for (int i = pay_q.size(); i < 46; i++) exp_q.push_back(8'h00);
    r = 32'hFFFF_FFFF;
    foreach (exp_q[i]) r = crc_norm(r, exp_q[i]);
    for (int i = 0; i < 32; i++) fcs[i] = ~r[31-i];
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  // Output capture and hold-while-stalled check.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", 32'(m_tdata), 32'(prev_data));
        chk("stall_valid", 32'(m_tvalid), 32'd1);
        chk("stall_last", 32'(m_tlast), 32'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        got_q.push_back(m_tdata);
        got_last.push_back(m_tlast);
        if (mon_chk_busy) chk("busy_in_frame", 32'(busy), 32'd1);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic send_frame(input bit bubbles, input int abort_at, input bit chk_lat);
    bit hs;
    int budget;
    for (int i = 0; i < pay_q.size(); i++) begin
      if (bubbles) begin
        while ($urandom_range(0, 1) == 1) begin
          s_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_tvalid = 1'b1;
      s_tdata  = pay_q[i];
      s_tlast  = (i == pay_q.size() - 1);
      if (i == 0 && chk_lat) begin
        @(negedge clk);
        chk("lat_pre_valid", 32'(m_tvalid), 32'd0);
        chk("lat_pre_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("lat_hdr_valid", 32'(m_tvalid), 32'd1);
        chk("lat_hdr_data", 32'(m_tdata), 32'hFF);
        chk("lat_busy", 32'(busy), 32'd1);
      end
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_last", 32'(m_tlast), 32'd0);
        chk("rst_mid_data", 32'(m_tdata), 32'h00);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_sready", 32'(s_tready), 32'd0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      budget = 0;
      do begin
        @(negedge clk);
        hs = s_tready;
        budget++;
      end while (!hs && budget < 2000);
      if (!hs) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        s_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_compare(input int exp_len, input string tag);
    int n;
    n = 0;
    while (!(got_q.size() > 0 && got_last[got_q.size()-1]) && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 5000) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_len));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == exp_len - 1));
    end
    @(negedge clk); #1;
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    got_q.delete();
    got_last.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    logic [31:0] c;

    // CRC step unit over the standard check string.
    s = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < s.len(); i++) begin
      cu_in   = c;
      cu_data = s[i];
      #1;
      c = cu_out;
    end
    chk("crc_check_value", ~c, 32'hCBF4_3926);

    #1;
    chk("rst_valid", 32'(m_tvalid), 32'd0);
    chk("rst_last", 32'(m_tlast), 32'd0);
    chk("rst_data", 32'(m_tdata), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_chk_busy = 1'b1;

    // 64-byte ramp, no padding.
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i));
    build_exp();
    send_frame(1'b0, -1, 1'b1);
    wait_compare(82, "f64");

    // 8-byte payload, 38 pad bytes.
    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'hA0 + 3 * i));
    build_exp();
    send_frame(1'b0, -1, 1'b0);
    wait_compare(64, "f8");

    // Single-byte payload, 45 pad bytes.
    pay_q.delete();
    pay_q.push_back(8'h5C);
    build_exp();
    send_frame(1'b0, -1, 1'b1);
    wait_compare(64, "f1");

    // 100-byte frame with upstream bubbles and downstream backpressure.
    pay_q.delete();
    for (int i = 0; i < 100; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    build_exp();
    rand_rdy = 1'b1;
    send_frame(1'b1, -1, 1'b0);
    wait_compare(118, "f100_stall");
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset during payload byte 20, then a clean frame.
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i) ^ 8'h5A);
    send_frame(1'b0, 19, 1'b0);
    got_q.delete();
    got_last.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_valid", 32'(m_tvalid), 32'd0);
    build_exp();
    send_frame(1'b0, -1, 1'b1);
    wait_compare(82, "f_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Ethernet II transmit framer, directly downstream of the UDP formatter's byte stream and upstream of the MAC/PHY adapter. Per frame it emits a 14-byte Ethernet header, passes the payload through, zero-pads short payloads to 46 bytes, and appends a CRC-32 FCS. Preamble, SFD and inter-frame gap are not inserted here; the PHY adapter owns them. Bubbles and backpressure are tolerated on both sides.

## Interface
- DST_MAC, 48'hFFFF_FFFF_FFFF: destination MAC, sent MSB byte first.
- SRC_MAC, 48'h02_00_00_00_00_01: source MAC, sent MSB byte first.
- ETHERTYPE, 16'h0800: EtherType field, sent MSB byte first.
- MIN_PAYLOAD, 46: minimum payload bytes before the FCS; shorter payloads are zero-padded up to this length.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  payload byte valid.
- s_axis_tready  out  1  payload byte accepted when tvalid && tready.
- s_axis_tlast  in  1  marks the last payload byte of the frame.
- m_axis_tdata  out  8  frame byte.
- m_axis_tvalid  out  1  frame byte valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  high on the final FCS byte.
- busy  out  1  high from frame start through acceptance of the last FCS byte.

## Operation
- States:
  - IDLE → HDR on s_axis_tvalid; no byte is consumed.
  - HDR: 14 bytes (DST_MAC, SRC_MAC, ETHERTYPE). → PAYLOAD.
  - PAYLOAD: pass-through. → PAD if the byte carrying tlast is accepted with payload count < MIN_PAYLOAD. → FCS if that count ≥ MIN_PAYLOAD.
  - PAD: emits 8'h00 until the count equals MIN_PAYLOAD. → FCS.
  - FCS: emits 4 bytes. → IDLE after the 4th byte is accepted downstream.
- Output register "load" condition: !m_axis_tvalid || m_axis_tready. A byte advances state and counters only on a load.
- s_axis_tready = (state == PAYLOAD) && load condition. The block has no internal FIFO.
- Upstream bubble in PAYLOAD: m_axis_tvalid drops to 0 on the next load. Frame content is unchanged.
- Payload counter: 11 bits, saturates at 2047. There is no maximum-length enforcement.
- Payload of 0 bytes is not possible, because tlast rides on a data byte.
- CRC-32 details:
  - Polynomial 0x04C11DB7 in reflected form (0xEDB88320), LSB-first per byte, init 0xFFFF_FFFF.
  - Updated with every header, payload and pad byte as it is loaded into the output register.
  - FCS = ~crc, sent as crc[7:0], [15:8], [23:16], [31:24]. The CRC is reinitialised in IDLE.
- tlast on an input byte outside PAYLOAD cannot occur, because tready is low there.

## Timing
- Reset values (async): state IDLE, busy 0, s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 8'h00, counters 0, crc 32'hFFFF_FFFF.
- Latency:
  - First header byte is valid 1 cycle after s_axis_tvalid is seen in IDLE.
  - First payload byte appears at m_axis 1 cycle after its input handshake.
- With m_axis_tready held at 1 and no input bubbles, throughput is 1 byte/cycle.
  - Frame length on the wire = 14 + max(N, MIN_PAYLOAD) + 4 bytes.
- busy rises the cycle after IDLE exits. It falls on the cycle after the last FCS byte is accepted.
- IDLE is held at least 1 cycle between frames, so there is a 1-cycle gap minimum before the next header byte.
- m_axis_tdata, m_axis_tvalid and m_axis_tlast are stable while tvalid && !tready.
- rst_n asserted mid-frame: all state returns to reset values immediately, and the partial frame is dropped. Upstream must also be reset.

## Structure
- eth_pkg holds:
  - the state enum;
  - ETH_HDR_BYTES = 14, ETH_FCS_BYTES = 4, ETH_MIN_PAYLOAD = 46;
  - CRC32_POLY_REFL = 32'hEDB88320, CRC32_INIT = 32'hFFFF_FFFF;
  - ETHERTYPE_IPV4 = 16'h0800.
- Sub-module eth_crc32_byte: combinational next-CRC from (crc_in[31:0], data[7:0]). It is reused later by the RX checker.
- The framer instantiates it once and holds the crc register itself.

## Test plan
- CRC unit check: eth_crc32_byte over ASCII "123456789" from init, then inverted → 32'hCBF43926.
- 64-byte payload 0x00..0x3F, m_axis_tready = 1 → 82 bytes:
  - first bytes FF FF FF FF FF FF 02 00 00 00 00 01 08 00;
  - payload unchanged, then an FCS matching a bench CRC-32 model;
  - tlast only on byte 82.
- 8-byte payload → 38 bytes of 00 padding. Frame is 64 bytes total, and the FCS covers the padding.
- 1-byte payload (tvalid+tlast in one cycle) → 45 pad bytes, 64-byte frame, busy high for the whole frame.
- Random tvalid bubbles upstream (≈50%) plus random m_axis_tready (≈30% low) on a 100-byte frame:
  - byte stream identical to the no-stall run;
  - no output change while tvalid && !tready.
- rst_n pulsed low during payload byte 20 → outputs at reset values that same cycle. The next frame after release is complete and correct.
